// File: rtl/peak_snapshot_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : peak_snapshot_regfile
//  Description : Double-buffered register file between the peak finder and a
//                byte-wide host slave port. Each peak frame (time counter,
//                PEAKS frequencies, PEAKS amplitudes) is captured into a
//                shadow bank and published atomically by flipping the bank
//                select, so a host read never sees a torn frame. Provides a
//                host lock, a sticky new-frame flag with level interrupt and a
//                saturating dropped-frame (OVERRUN) counter.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1                  system clock
//    reset       in   1                  asynchronous active-low reset
//    valid_in    in   1                  frame inputs valid this cycle
//    counter_in  in   COUNTER_WIDTH      frame time counter
//    freqs_in    in   PEAKS*FREQ_WIDTH   peak i at [i*FREQ_WIDTH +: FREQ_WIDTH]
//    ampls_in    in   PEAKS*AMPL_WIDTH   peak i at [i*AMPL_WIDTH +: AMPL_WIDTH]
//    chipselect  in   1                  slave select
//    read        in   1                  read strobe (qualified by chipselect)
//    write       in   1                  write strobe (qualified by chipselect)
//    address     in   8                  byte address
//    writedata   in   8                  write data
//    readdata    out  8                  registered read data
//    irq         out  1                  registered new_frame & irq_en
//  Address map (multi-byte fields MSB first)
//    [0,CB)             counter
//    [CB,CB+PEAKS)      frequencies, zero-extended to a byte
//    next PEAKS*AB      amplitudes, peak 0 first, zero-extended at MSB
//    0xFC OVERRUN (ro)  0xFD CTRL (rw)  0xFE STATUS (ro)  0xFF ID (ro)
// ============================================================================
module peak_snapshot_regfile #(
    parameter int         PEAKS         = 6,
    parameter int         FREQ_WIDTH    = 8,
    parameter int         AMPL_WIDTH    = 16,
    parameter int         COUNTER_WIDTH = 32,
    parameter logic [7:0] ID_VALUE      = 8'h5A
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_in,
    input  logic [COUNTER_WIDTH-1:0]      counter_in,
    input  logic [PEAKS*FREQ_WIDTH-1:0]   freqs_in,
    input  logic [PEAKS*AMPL_WIDTH-1:0]   ampls_in,
    input  logic                          chipselect,
    input  logic                          read,
    input  logic                          write,
    input  logic [7:0]                    address,
    input  logic [7:0]                    writedata,
    output logic [7:0]                    readdata,
    output logic                          irq
);

    localparam int         C_CB          = COUNTER_WIDTH / 8;
    localparam int         C_AB          = (AMPL_WIDTH + 7) / 8;
    localparam int         C_AMPL_EXT    = C_AB * 8;
    localparam int         C_FRAME_BYTES = C_CB + PEAKS * (1 + C_AB);
    localparam logic [7:0] C_ADDR_OVR    = 8'hFC;
    localparam logic [7:0] C_ADDR_CTRL   = 8'hFD;
    localparam logic [7:0] C_ADDR_STATUS = 8'hFE;
    localparam logic [7:0] C_ADDR_ID     = 8'hFF;

    // The frame must not collide with the control registers at 0xFC..0xFF.
    generate
        if (C_FRAME_BYTES > 252) begin : g_map_overflow
            $error("peak_snapshot_regfile: frame of %0d bytes overlaps control registers",
                   C_FRAME_BYTES);
        end
        if ((COUNTER_WIDTH % 8) != 0 || FREQ_WIDTH > 8) begin : g_width_check
            $error("peak_snapshot_regfile: unsupported COUNTER_WIDTH/FREQ_WIDTH");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [COUNTER_WIDTH-1:0]    r_cnt_bank  [2];
    logic [PEAKS*FREQ_WIDTH-1:0] r_freq_bank [2];
    logic [PEAKS*AMPL_WIDTH-1:0] r_ampl_bank [2];
    logic                        r_pub_sel;
    logic                        r_shadow_full;
    logic                        r_new_frame;
    logic                        r_lock;
    logic                        r_irq_en;
    logic                        r_irq;
    logic [7:0]                  r_overrun;
    logic [7:0]                  r_readdata;

    // ------------------------------------------------------------------
    // Bus decode and publish decisions
    // ------------------------------------------------------------------
    logic w_rd;
    logic w_wr;
    logic w_ctrl_wr;
    logic w_status_rd;
    logic w_release;
    logic w_publish_new;
    logic w_publish_old;
    logic w_toggle;
    logic w_hold;
    logic w_ovr_inc;
    logic w_ovr_clr;
    logic w_shadow_sel;

    assign w_rd         = chipselect & read;
    assign w_wr         = chipselect & write;
    assign w_ctrl_wr    = w_wr & (address == C_ADDR_CTRL);
    assign w_status_rd  = w_rd & (address == C_ADDR_STATUS);
    assign w_shadow_sel = ~r_pub_sel;

    // A lock 1->0 write releases the host hold this very edge.
    assign w_release     = w_ctrl_wr & r_lock & ~writedata[0];
    // Incoming frame goes straight to the host unless the host holds the lock.
    // A lock 0->1 write still sees r_lock=0 here, so that frame is published.
    assign w_publish_new = valid_in & (~r_lock | w_release);
    // Release without a new frame: publish the frame parked in the shadow bank.
    assign w_publish_old = ~valid_in & w_release & r_shadow_full;
    assign w_toggle      = w_publish_new | w_publish_old;
    assign w_hold        = valid_in & r_lock & ~w_release;
    // A parked frame is lost whenever a new frame arrives while locked,
    // whether it is parked over or discarded by a simultaneous release.
    assign w_ovr_inc     = valid_in & r_lock & r_shadow_full;
    assign w_ovr_clr     = w_ctrl_wr & writedata[7];

    // ------------------------------------------------------------------
    // Published-bank byte view
    // ------------------------------------------------------------------
    logic [COUNTER_WIDTH-1:0]    w_pub_cnt;
    logic [PEAKS*FREQ_WIDTH-1:0] w_pub_freqs;
    logic [PEAKS*AMPL_WIDTH-1:0] w_pub_ampls;
    logic [C_AMPL_EXT-1:0]       w_ampl_ext;
    logic [7:0]                  w_frame_byte;

    assign w_pub_cnt   = r_cnt_bank[r_pub_sel];
    assign w_pub_freqs = r_freq_bank[r_pub_sel];
    assign w_pub_ampls = r_ampl_bank[r_pub_sel];

    always_comb begin
        w_frame_byte = 8'h00;
        w_ampl_ext   = '0;
        for (int b = 0; b < C_CB; b++) begin
            if (address == 8'(b)) begin
                w_frame_byte = w_pub_cnt[(C_CB-1-b)*8 +: 8];
            end
        end
        for (int p = 0; p < PEAKS; p++) begin
            if (address == 8'(C_CB + p)) begin
                w_frame_byte = 8'(w_pub_freqs[p*FREQ_WIDTH +: FREQ_WIDTH]);
            end
            for (int j = 0; j < C_AB; j++) begin
                if (address == 8'(C_CB + PEAKS + p*C_AB + j)) begin
                    w_ampl_ext   = C_AMPL_EXT'(w_pub_ampls[p*AMPL_WIDTH +: AMPL_WIDTH]);
                    w_frame_byte = w_ampl_ext[(C_AB-1-j)*8 +: 8];
                end
            end
        end
    end

    logic [7:0] w_rdata;

    always_comb begin
        case (address)
            C_ADDR_OVR:    w_rdata = r_overrun;
            C_ADDR_CTRL:   w_rdata = {6'b0, r_irq_en, r_lock};
            C_ADDR_STATUS: w_rdata = {5'b0, r_lock, r_shadow_full, r_new_frame};
            C_ADDR_ID:     w_rdata = ID_VALUE;
            default:       w_rdata = w_frame_byte;  // 0 for unmapped addresses
        endcase
    end

    // CTRL bits 6:2 are reserved and have no storage.
    logic w_unused;
    assign w_unused = &{1'b0, writedata[6:2]};

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                r_cnt_bank[k]  <= '0;
                r_freq_bank[k] <= '0;
                r_ampl_bank[k] <= '0;
            end
            r_pub_sel     <= 1'b0;
            r_shadow_full <= 1'b0;
            r_new_frame   <= 1'b0;
            r_lock        <= 1'b0;
            r_irq_en      <= 1'b0;
            r_irq         <= 1'b0;
            r_overrun     <= 8'h00;
            r_readdata    <= 8'h00;
        end else begin
            if (valid_in) begin
                r_cnt_bank[w_shadow_sel]  <= counter_in;
                r_freq_bank[w_shadow_sel] <= freqs_in;
                r_ampl_bank[w_shadow_sel] <= ampls_in;
            end

            if (w_toggle) begin
                r_pub_sel     <= ~r_pub_sel;
                r_shadow_full <= 1'b0;
            end else if (w_hold) begin
                r_shadow_full <= 1'b1;
            end

            // A publish outranks a simultaneous STATUS read clear.
            if (w_toggle) begin
                r_new_frame <= 1'b1;
            end else if (w_status_rd) begin
                r_new_frame <= 1'b0;
            end

            if (w_ovr_clr) begin
                r_overrun <= w_ovr_inc ? 8'h01 : 8'h00;
            end else if (w_ovr_inc && (r_overrun != 8'hFF)) begin
                r_overrun <= r_overrun + 8'h01;
            end

            if (w_ctrl_wr) begin
                r_lock   <= writedata[0];
                r_irq_en <= writedata[1];
            end

            if (w_rd) begin
                r_readdata <= w_rdata;
            end

            r_irq <= r_new_frame & r_irq_en;
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_peak_snapshot_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_peak_snapshot_regfile
//  Description : Self-checking bench for peak_snapshot_regfile. A frame-level
//                reference model (published frame / parked frame as byte
//                images of the address map) predicts readdata and irq every
//                cycle, under directed scenarios and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_peak_snapshot_regfile;

    localparam int CB = 4;
    localparam int AB = 2;
    localparam int P  = 6;
    localparam int FW = 8;
    localparam int AW = 16;
    localparam int FB = CB + P * (1 + AB);

    logic         clk;
    logic         reset;
    logic         valid_in;
    logic [31:0]  counter_in;
    logic [47:0]  freqs_in;
    logic [95:0]  ampls_in;
    logic         chipselect;
    logic         read;
    logic         write;
    logic [7:0]   address;
    logic [7:0]   writedata;
    logic [7:0]   readdata;
    logic         irq;

    int n_checks = 0;
    int n_errors = 0;

    peak_snapshot_regfile #(
        .PEAKS         (P),
        .FREQ_WIDTH    (FW),
        .AMPL_WIDTH    (AW),
        .COUNTER_WIDTH (32),
        .ID_VALUE      (8'h5A)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .counter_in (counter_in),
        .freqs_in   (freqs_in),
        .ampls_in   (ampls_in),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: frames held as byte images of the address map
    // ------------------------------------------------------------------
    logic [7:0] m_pub  [0:FB-1];
    logic [7:0] m_pend [0:FB-1];
    bit         m_sf, m_new, m_lock, m_irqen, m_irq;
    int         m_ovr;
    logic [7:0] m_rd;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < FB; a++) begin
            m_pub[a]  = 8'h00;
            m_pend[a] = 8'h00;
        end
        m_sf = 0; m_new = 0; m_lock = 0; m_irqen = 0; m_irq = 0;
        m_ovr = 0; m_rd = 8'h00;
    endtask

    // Byte 'a' of the frame currently presented on the capture inputs.
    function automatic logic [7:0] in_byte(input int a);
        logic [95:0] v;
        int k;
        if (a < CB) begin
            v = 96'(counter_in) >> (8 * (CB - 1 - a));
            return v[7:0];
        end
        if (a < CB + P) begin
            v = 96'(freqs_in) >> (FW * (a - CB));
            return v[7:0];
        end
        k = a - CB - P;
        v = ampls_in >> (AW * (k / AB));
        v = v & ((96'd1 << AW) - 96'd1);
        v = v >> (8 * (AB - 1 - (k % AB)));
        return v[7:0];
    endfunction

    function automatic logic [7:0] lookup(input logic [7:0] a);
        if (int'(a) < FB) return m_pub[int'(a)];
        case (a)
            8'hFC:   return 8'(m_ovr);
            8'hFD:   return {6'b0, m_irqen, m_lock};
            8'hFE:   return {5'b0, m_lock, m_sf, m_new};
            8'hFF:   return 8'h5A;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_update();
        bit rd, wr, ctrl_wr, st_rd, rel, inc, pub, irq_next;
        logic [7:0] rv;
        if (!reset) begin
            model_reset();
            return;
        end
        rd       = chipselect && read;
        wr       = chipselect && write;
        rv       = lookup(address);
        ctrl_wr  = wr && (address == 8'hFD);
        st_rd    = rd && (address == 8'hFE);
        rel      = ctrl_wr && m_lock && !writedata[0];
        irq_next = m_new && m_irqen;
        inc = 0;
        pub = 0;
        if (valid_in) begin
            if (!m_lock || rel) begin
                for (int a = 0; a < FB; a++) m_pub[a] = in_byte(a);
                if (m_sf) inc = 1;
                m_sf = 0;
                pub  = 1;
            end else begin
                if (m_sf) inc = 1;
                for (int a = 0; a < FB; a++) m_pend[a] = in_byte(a);
                m_sf = 1;
            end
        end else if (rel && m_sf) begin
            for (int a = 0; a < FB; a++) m_pub[a] = m_pend[a];
            m_sf = 0;
            pub  = 1;
        end
        if (pub) m_new = 1;
        else if (st_rd) m_new = 0;
        if (ctrl_wr && writedata[7]) m_ovr = inc ? 1 : 0;
        else if (inc && m_ovr < 255) m_ovr = m_ovr + 1;
        if (ctrl_wr) begin
            m_lock  = writedata[0];
            m_irqen = writedata[1];
        end
        if (rd) m_rd = rv;
        m_irq = irq_next;
    endtask

    // One clock: model advances on the edge, outputs compared 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_value("readdata", {24'd0, readdata}, {24'd0, m_rd});
        check_value("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic idle_inputs();
        valid_in = 0; chipselect = 0; read = 0; write = 0;
        address = 8'h00; writedata = 8'h00;
    endtask

    task automatic bus(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        chipselect = 1; read = r; write = w; address = a; writedata = d;
        step();
        chipselect = 0; read = 0; write = 0;
    endtask

    task automatic rd_expect(input string tag, input logic [7:0] a, input logic [7:0] exp);
        bus(1'b1, 1'b0, a, 8'h00);
        check_value(tag, {24'd0, readdata}, {24'd0, exp});
    endtask

    task automatic send_frame(input logic [31:0] c, input logic [7:0] f0, input logic [15:0] a0);
        valid_in   = 1;
        counter_in = c;
        freqs_in   = {$urandom, 8'($urandom), f0};
        ampls_in   = {$urandom, $urandom, 16'($urandom), a0};
        step();
        valid_in = 0;
    endtask

    initial begin
        reset = 0;
        counter_in = '0; freqs_in = '0; ampls_in = '0;
        idle_inputs();
        model_reset();
        repeat (3) step();
        check_value("reset_readdata", {24'd0, readdata}, 32'h0);
        check_value("reset_irq", {31'd0, irq}, 32'h0);
        reset = 1;
        step();

        // Identification and idle status
        rd_expect("id", 8'hFF, 8'h5A);
        rd_expect("status_idle", 8'hFE, 8'h00);
        rd_expect("addr0_idle", 8'h00, 8'h00);
        check_value("irq_idle", {31'd0, irq}, 32'h0);

        // Unlocked capture is published immediately
        send_frame(32'h01020304, 8'h11, 16'hABCD);
        rd_expect("cnt_b0", 8'h00, 8'h01);
        rd_expect("cnt_b1", 8'h01, 8'h02);
        rd_expect("cnt_b2", 8'h02, 8'h03);
        rd_expect("cnt_b3", 8'h03, 8'h04);
        rd_expect("freq0", 8'h04, 8'h11);
        rd_expect("ampl0_hi", 8'h0A, 8'hAB);
        rd_expect("ampl0_lo", 8'h0B, 8'hCD);
        rd_expect("status_new", 8'hFE, 8'h01);
        rd_expect("status_cleared", 8'hFE, 8'h00);

        // Locked: frames park in shadow, extra ones count as overruns
        bus(1'b0, 1'b1, 8'hFD, 8'h01);
        send_frame(32'd5, 8'h00, 16'h0000);
        send_frame(32'd6, 8'h00, 16'h0000);
        send_frame(32'd7, 8'h00, 16'h0000);
        rd_expect("locked_cnt0", 8'h00, 8'h01);
        rd_expect("locked_cnt3", 8'h03, 8'h04);
        rd_expect("overrun_2", 8'hFC, 8'h02);
        rd_expect("status_locked", 8'hFE, 8'h06);
        bus(1'b0, 1'b1, 8'hFD, 8'h00);
        rd_expect("unlock_cnt3", 8'h03, 8'h07);
        rd_expect("unlock_cnt0", 8'h00, 8'h00);
        rd_expect("status_unlock", 8'hFE, 8'h01);

        // Interrupt timing
        bus(1'b0, 1'b1, 8'hFD, 8'h02);
        check_value("irq_before", {31'd0, irq}, 32'h0);
        send_frame(32'd8, 8'h00, 16'h0000);
        check_value("irq_edge1", {31'd0, irq}, 32'h0);
        step();
        check_value("irq_edge2", {31'd0, irq}, 32'h1);
        rd_expect("status_irq", 8'hFE, 8'h01);
        step();
        check_value("irq_cleared", {31'd0, irq}, 32'h0);
        bus(1'b0, 1'b1, 8'hFD, 8'h80);
        rd_expect("overrun_clr", 8'hFC, 8'h00);

        // Unlock write coincident with a new frame while shadow is full
        bus(1'b0, 1'b1, 8'hFD, 8'h01);
        send_frame(32'd20, 8'h00, 16'h0000);
        valid_in = 1; counter_in = 32'd9;
        chipselect = 1; write = 1; address = 8'hFD; writedata = 8'h00;
        step();
        idle_inputs();
        rd_expect("simul_cnt3", 8'h03, 8'h09);
        rd_expect("simul_cnt0", 8'h00, 8'h00);
        rd_expect("simul_ovr", 8'hFC, 8'h01);
        rd_expect("simul_status", 8'hFE, 8'h01);

        // Asynchronous reset in the middle of a locked sequence and a read
        bus(1'b0, 1'b1, 8'hFD, 8'h03);
        send_frame(32'd30, 8'h00, 16'h0000);
        send_frame(32'd31, 8'h00, 16'h0000);
        chipselect = 1; read = 1; address = 8'hFF; valid_in = 1;
        #3;
        reset = 0;
        #1;
        check_value("async_rst_rdata", {24'd0, readdata}, 32'h0);
        check_value("async_rst_irq", {31'd0, irq}, 32'h0);
        model_reset();
        idle_inputs();
        repeat (2) step();
        reset = 1;
        for (int a = 0; a < 256; a++) begin
            rd_expect("post_reset_map", 8'(a), (a == 255) ? 8'h5A : 8'h00);
        end
        check_value("post_reset_irq", {31'd0, irq}, 32'h0);

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 2000; cyc++) begin
            valid_in   = ($urandom_range(0, 3) == 0);
            counter_in = $urandom;
            freqs_in   = {$urandom, 16'($urandom)};
            ampls_in   = {$urandom, $urandom, $urandom};
            chipselect = ($urandom_range(0, 4) != 0);
            read       = $urandom_range(0, 1) == 1;
            write      = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 2))
                0:       address = 8'hFC + 8'($urandom_range(0, 3));
                1:       address = 8'($urandom_range(0, FB + 1));
                default: address = 8'($urandom);
            endcase
            writedata    = 8'($urandom);
            writedata[7] = ($urandom_range(0, 7) == 0);
            if (cyc == 1000) reset = 0;
            if (cyc == 1003) reset = 1;
            step();
        end
        idle_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
